// File: rtl/fifo_pkg.sv
// Shared definitions for the conditional FIFO family used on the TC/VC
// buffering path: output-mode constants, default virtual-channel buffer
// geometry and a ceil(log2) helper usable in constant expressions.
package fifo_pkg;

  // Read-data presentation modes.
  localparam int OUT_COMB = 0;  // read data follows rdaddr combinationally
  localparam int OUT_REGD = 1;  // read data registered, qualified by fifo_valid

  // Default geometry of one virtual-channel buffer.
  localparam int VC_BW    = 6;
  localparam int VC_DEPTH = 16;

  // Smallest n with 2**n >= value; returns 1 for value <= 2 so pointers
  // always have at least one bit.
  function automatic int clog2(input int value);
    int n;
    n = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Storage array for fifo_cond_param.
// Ports:
//   clk        write clock (rising edge)
//   wr_en_i    write strobe; the array changes only when it is high
//   wr_addr_i  write address, 0..DEPTH-1
//   wr_data_i  write data
//   rd_addr_i  read address, 0..DEPTH-1
//   rd_data_o  contents at rd_addr_i (asynchronous read)
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int BW    = VC_BW,
  parameter int DEPTH = VC_DEPTH,
  parameter int AW    = clog2(VC_DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [BW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [BW-1:0] rd_data_o
);

  logic [BW-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset on purpose; a reset branch would turn it into
  // DEPTH*BW resettable flops instead of a RAM, and occupancy tracking already
  // guarantees that stale words are never presented as valid data.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_cond_param.sv
// Conditional FIFO for one virtual channel, between the packet classifier
// and the VC arbiter. Any DEPTH >= 2 is supported (pointers wrap explicitly).
// Ports:
//   clk, reset_L       clock (rising edge) and async active-low reset
//   fifo_wr / _data_in write request and data
//   fifo_rd            read request
//   umbral_bajo/_alto  thresholds for almost_empty (fill <= bajo) and
//                      almost_full (fill >= alto)
//   err_clr            clears the sticky error flags (a same-cycle set wins)
//   fifo_data_out      read data; fifo_valid marks a popped word
//   fifo_fill          occupancy 0..DEPTH
//   fifo_full/_empty/_almost_full/_almost_empty  status from registered fill
//   overrun_err/underrun_err/error_output        sticky rejected-access flags
module fifo_cond_param
  import fifo_pkg::*;
#(
  parameter  int BW      = VC_BW,
  parameter  int DEPTH   = VC_DEPTH,
  parameter  int OUT_REG = OUT_REGD,
  localparam int AW      = clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          fifo_wr,
  input  logic [BW-1:0] fifo_data_in,
  input  logic          fifo_rd,
  input  logic [CW-1:0] umbral_bajo,
  input  logic [CW-1:0] umbral_alto,
  input  logic          err_clr,
  output logic [BW-1:0] fifo_data_out,
  output logic          fifo_valid,
  output logic [CW-1:0] fifo_fill,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_almost_full,
  output logic          fifo_almost_empty,
  output logic          overrun_err,
  output logic          underrun_err,
  output logic          error_output
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          rd_ok, wr_ok;
  logic [BW-1:0] rd_data;

  // Explicit wrap so that non-power-of-two depths never address past DEPTH-1.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign fifo_empty        = (fill_q == '0);
  assign fifo_full         = (fill_q == CW'(DEPTH));
  assign fifo_almost_full  = (fill_q >= umbral_alto);
  assign fifo_almost_empty = (fill_q <= umbral_bajo);
  assign fifo_fill         = fill_q;

  // A full FIFO still accepts a write when a read frees a slot in the same
  // cycle. An empty FIFO never forwards a same-cycle write to the reader.
  assign rd_ok = fifo_rd & ~fifo_empty;
  assign wr_ok = fifo_wr & (~fifo_full | rd_ok);

  // NOTE: every signal written here gets a value on every path (defaults
  // first), otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({wr_ok, rd_ok})
      2'b10:   fill_d = fill_q + CW'(1);
      2'b01:   fill_d = fill_q - CW'(1);
      default: fill_d = fill_q;
    endcase
    // Set has priority over clear so an error in the clearing cycle is kept.
    overrun_d  = (overrun_q & ~err_clr) | (fifo_wr & ~wr_ok);
    underrun_d = (underrun_q & ~err_clr) | (fifo_rd & ~rd_ok);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign overrun_err  = overrun_q;
  assign underrun_err = underrun_q;
  assign error_output = overrun_q | underrun_q;

  fifo_mem_dp #(
    .BW    (BW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (fifo_data_in),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  if (OUT_REG == OUT_COMB) begin : g_out_comb
    // Head word is shown whenever a read is requested; only rd_ok qualifies it.
    always_comb begin
      fifo_data_out = fifo_rd ? rd_data : '0;
      fifo_valid    = rd_ok;
    end
  end else begin : g_out_reg
    logic [BW-1:0] dout_q;
    logic          valid_q;

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) dout_q <= rd_data;
      end
    end

    assign fifo_data_out = dout_q;
    assign fifo_valid    = valid_q;
  end

endmodule

// File: tb/tb_fifo_cond_param.sv
// Self-checking bench for fifo_cond_param. Three instances share clock,
// reset, data and thresholds; only the selected instance sees wr/rd:
//   0: DEPTH=16, registered output   1: DEPTH=12, registered output
//   2: DEPTH=16, combinational output
// A queue-based reference model predicts all outputs every cycle.
module tb_fifo_cond_param;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [5:0] din = '0;
  logic [4:0] thr_lo = 5'd2;
  logic [4:0] thr_hi = 5'd14;
  logic       err_clr = 1'b0;
  logic [2:0] wr_v = '0;
  logic [2:0] rd_v = '0;

  logic [5:0] dout   [3];
  logic       valid  [3];
  logic [4:0] fill   [3];
  logic       full   [3];
  logic       empty  [3];
  logic       afull  [3];
  logic       aempty [3];
  logic       ovr    [3];
  logic       udr    [3];
  logic       errout [3];

  always #5 clk = ~clk;

  fifo_cond_param #(.BW(6), .DEPTH(16), .OUT_REG(1)) u_dut16 (
    .clk(clk), .reset_L(reset_L), .fifo_wr(wr_v[0]), .fifo_data_in(din),
    .fifo_rd(rd_v[0]), .umbral_bajo(thr_lo), .umbral_alto(thr_hi), .err_clr(err_clr),
    .fifo_data_out(dout[0]), .fifo_valid(valid[0]), .fifo_fill(fill[0]),
    .fifo_full(full[0]), .fifo_empty(empty[0]), .fifo_almost_full(afull[0]),
    .fifo_almost_empty(aempty[0]), .overrun_err(ovr[0]), .underrun_err(udr[0]),
    .error_output(errout[0]));

  fifo_cond_param #(.BW(6), .DEPTH(12), .OUT_REG(1)) u_dut12 (
    .clk(clk), .reset_L(reset_L), .fifo_wr(wr_v[1]), .fifo_data_in(din),
    .fifo_rd(rd_v[1]), .umbral_bajo(thr_lo), .umbral_alto(thr_hi), .err_clr(err_clr),
    .fifo_data_out(dout[1]), .fifo_valid(valid[1]), .fifo_fill(fill[1]),
    .fifo_full(full[1]), .fifo_empty(empty[1]), .fifo_almost_full(afull[1]),
    .fifo_almost_empty(aempty[1]), .overrun_err(ovr[1]), .underrun_err(udr[1]),
    .error_output(errout[1]));

  fifo_cond_param #(.BW(6), .DEPTH(16), .OUT_REG(0)) u_dut_comb (
    .clk(clk), .reset_L(reset_L), .fifo_wr(wr_v[2]), .fifo_data_in(din),
    .fifo_rd(rd_v[2]), .umbral_bajo(thr_lo), .umbral_alto(thr_hi), .err_clr(err_clr),
    .fifo_data_out(dout[2]), .fifo_valid(valid[2]), .fifo_fill(fill[2]),
    .fifo_full(full[2]), .fifo_empty(empty[2]), .fifo_almost_full(afull[2]),
    .fifo_almost_empty(aempty[2]), .overrun_err(ovr[2]), .underrun_err(udr[2]),
    .error_output(errout[2]));

  // Reference model state.
  int         sel = 0;
  int         m_depth = 16;
  bit         m_outreg = 1'b1;
  logic [5:0] q[$];
  bit         m_ovr, m_udr, m_valid;
  logic [5:0] m_dout;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (dut%0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovr   = 1'b0;
    m_udr   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  // Compare every observable output of the selected instance with the model.
  task automatic check_all(input bit rd);
    int n;
    n = q.size();
    check("fill", 32'(fill[sel]), 32'(n));
    check("empty", 32'(empty[sel]), 32'(n == 0));
    check("full", 32'(full[sel]), 32'(n == m_depth));
    check("almost_full", 32'(afull[sel]), 32'(n >= int'(thr_hi)));
    check("almost_empty", 32'(aempty[sel]), 32'(n <= int'(thr_lo)));
    check("overrun", 32'(ovr[sel]), 32'(m_ovr));
    check("underrun", 32'(udr[sel]), 32'(m_udr));
    check("error_output", 32'(errout[sel]), 32'(m_ovr | m_udr));
    if (m_outreg) begin
      check("valid", 32'(valid[sel]), 32'(m_valid));
      check("data_out", 32'(dout[sel]), 32'(m_dout));
    end else begin
      check("valid_comb", 32'(valid[sel]), 32'(rd && n > 0));
      if (!rd)        check("data_out_idle", 32'(dout[sel]), 32'd0);
      else if (n > 0) check("data_out_comb", 32'(dout[sel]), 32'(q[0]));
    end
  endtask

  // One clock: drive on the falling edge, check just after, then advance the
  // model by what the rising edge should do.
  task automatic cycle(input bit wr, input bit rd, input logic [5:0] data, input bit clr);
    bit rd_ok, wr_ok;
    @(negedge clk);
    wr_v = '0;
    rd_v = '0;
    wr_v[sel] = wr;
    rd_v[sel] = rd;
    din = data;
    err_clr = clr;
    #1;
    check_all(rd);
    rd_ok = rd && q.size() != 0;
    wr_ok = wr && (q.size() != m_depth || rd_ok);
    if (m_outreg) begin
      m_valid = rd_ok;
      if (rd_ok) m_dout = q[0];
    end
    if (rd_ok) void'(q.pop_front());
    if (wr_ok) q.push_back(data);
    m_ovr = (m_ovr && !clr) || (wr && !wr_ok);
    m_udr = (m_udr && !clr) || (rd && !rd_ok);
  endtask

  task automatic select_and_reset(input int idx);
    @(negedge clk);
    wr_v = '0;
    rd_v = '0;
    err_clr = 1'b0;
    sel = idx;
    m_depth = (idx == 1) ? 12 : 16;
    m_outreg = (idx != 2);
    reset_L = 1'b0;
    #2;
    model_clear();
    check_all(1'b0);
    reset_L = 1'b1;
  endtask

  // Assert reset between clock edges and look at the outputs before any edge.
  task automatic mid_reset(input bit rd);
    @(negedge clk);
    wr_v = '0;
    rd_v = '0;
    rd_v[sel] = rd;
    err_clr = 1'b0;
    #1;
    check("pre_reset_valid", 32'(valid[sel]),
          32'(m_outreg ? m_valid : (rd && q.size() > 0)));
    #1;
    reset_L = 1'b0;
    #1;
    check("rst_fill", 32'(fill[sel]), 32'd0);
    check("rst_empty", 32'(empty[sel]), 32'd1);
    check("rst_overrun", 32'(ovr[sel]), 32'd0);
    check("rst_underrun", 32'(udr[sel]), 32'd0);
    check("rst_error_output", 32'(errout[sel]), 32'd0);
    check("rst_valid", 32'(valid[sel]), 32'd0);
    if (m_outreg) check("rst_data_out", 32'(dout[sel]), 32'd0);
    rd_v = '0;
    @(negedge clk);
    #1;
    reset_L = 1'b1;
    model_clear();
  endtask

  task automatic random_run(input int cycles, input int pw, input int pr, input bit rand_thr);
    for (int i = 0; i < cycles; i++) begin
      if (rand_thr && (i % 20) == 0) begin
        thr_lo = 5'($urandom_range(0, 31));
        thr_hi = 5'($urandom_range(0, 31));
      end
      cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            6'($urandom), $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    // Instance 0: directed sequence then random traffic.
    select_and_reset(0);
    thr_lo = 5'd2;
    thr_hi = 5'd14;
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 6'(i), 1'b0);
    cycle(1'b0, 1'b0, 6'h00, 1'b0);   // full, fill 16
    cycle(1'b1, 1'b0, 6'h15, 1'b0);   // rejected write
    cycle(1'b0, 1'b0, 6'h00, 1'b0);   // overrun visible
    cycle(1'b0, 1'b0, 6'h00, 1'b1);   // clear
    cycle(1'b1, 1'b1, 6'h3F, 1'b0);   // full rd+wr, pops 0x01
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 6'h00, 1'b0);
    cycle(1'b0, 1'b0, 6'h00, 1'b0);
    cycle(1'b1, 1'b1, 6'h2A, 1'b0);   // empty rd+wr: underrun, write kept
    cycle(1'b0, 1'b1, 6'h00, 1'b0);   // returns 0x2A
    cycle(1'b0, 1'b0, 6'h00, 1'b0);
    random_run(150, 70, 30, 1'b1);
    random_run(150, 30, 70, 1'b1);
    random_run(100, 50, 50, 1'b1);
    // Drop an in-flight registered valid with a mid-cycle reset.
    select_and_reset(0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'(i + 7), 1'b0);
    cycle(1'b0, 1'b1, 6'h00, 1'b0);
    mid_reset(1'b0);
    cycle(1'b0, 1'b0, 6'h00, 1'b0);

    // Instance 1: DEPTH=12, fixed thresholds, interleaved traffic across wraps.
    select_and_reset(1);
    thr_lo = 5'd2;
    thr_hi = 5'd10;
    random_run(60, 80, 30, 1'b0);
    random_run(120, 50, 50, 1'b0);
    random_run(60, 30, 80, 1'b0);
    thr_lo = 5'd12;                   // always almost_empty
    thr_hi = 5'd0;                    // always almost_full
    random_run(40, 60, 40, 1'b0);
    random_run(120, 55, 45, 1'b1);

    // Instance 2: combinational output.
    select_and_reset(2);
    thr_lo = 5'd2;
    thr_hi = 5'd14;
    random_run(200, 55, 45, 1'b1);
    select_and_reset(2);
    cycle(1'b0, 1'b1, 6'h00, 1'b0);   // underrun on empty
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 6'(i + 33), 1'b0);
    mid_reset(1'b1);                  // fill 5, read pending, error set
    cycle(1'b0, 1'b0, 6'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
